// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between instruction fetch
// and data access. Requests are serialised through an IDLE/ACCESS/DONE FSM with
// a fixed number of memory wait states; simultaneous requests are resolved
// round-robin, with data winning the first tie after reset.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  owner_e            last_owner_q, last_owner_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant_data;

  // State and latched-transaction registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_owner_q <= OWN_IF;
      owner_q      <= OWN_IF;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state logic: arbitration in IDLE, wait-state counting in ACCESS
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    grant_data   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // Data wins when alone, or on a tie when fetch owned the port last
          grant_data   = d_req && (!if_req || (last_owner_q == OWN_IF));
          owner_d      = grant_data ? OWN_D : OWN_IF;
          last_owner_d = grant_data ? OWN_D : OWN_IF;
          addr_d       = grant_data ? d_addr : if_addr;
          we_d         = grant_data && d_we;
          wdata_d      = grant_data ? d_wdata : '0;
          cnt_d        = '0;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    mem_en    = (state_q == ACCESS);
    mem_we    = (state_q == ACCESS) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_ack    = (state_q == DONE) && (owner_q == OWN_IF);
    d_ack     = (state_q == DONE) && (owner_q == OWN_D);
    if_rdata  = rdata_q;
    d_rdata   = rdata_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed stimulus with a scoreboard of
// expected acks, expected memory accesses and time-stamped output probes,
// all compared by a single negedge monitor.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  // Memory model: read data is the address XOR this key
  localparam logic [31:0] K = 32'h2010FFBF;

  localparam int S_MEM_EN = 0, S_MEM_WE = 1, S_IF_ACK = 2, S_D_ACK = 3, S_BUSY = 4;
  localparam int S_MEM_ADDR = 5, S_MEM_WDATA = 6, S_IF_RDATA = 7, S_D_RDATA = 8;
  localparam int S_B_MEM_EN = 9, S_B_MEM_ADDR = 10, S_B_D_ACK = 11, S_B_D_RDATA = 12, S_B_IF_ACK = 13;

  logic clk = 1'b0;
  logic reset;

  logic        if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, busy;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        b_if_req, b_if_ack, b_d_req, b_d_we, b_d_ack, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  assign mem_rdata   = mem_addr ^ K;
  assign b_mem_rdata = b_mem_addr ^ K;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit is_d; logic [31:0] rdata; int cyc; } ack_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; int en_len; int busy_len; } acc_t;
  typedef struct { int cyc; int sel; logic [31:0] exp; string name; } probe_t;

  ack_t   ack_q[$];
  acc_t   acc_q[$];
  probe_t probe_q[$];

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int busy_cnt = 0;
  bit prev_ack = 1'b0;
  bit done = 1'b0;

  function automatic logic [31:0] sig(int sel);
    case (sel)
      S_MEM_EN:     return 32'(mem_en);
      S_MEM_WE:     return 32'(mem_we);
      S_IF_ACK:     return 32'(if_ack);
      S_D_ACK:      return 32'(d_ack);
      S_BUSY:       return 32'(busy);
      S_MEM_ADDR:   return mem_addr;
      S_MEM_WDATA:  return mem_wdata;
      S_IF_RDATA:   return if_rdata;
      S_D_RDATA:    return d_rdata;
      S_B_MEM_EN:   return 32'(b_mem_en);
      S_B_MEM_ADDR: return b_mem_addr;
      S_B_D_ACK:    return 32'(b_d_ack);
      S_B_D_RDATA:  return b_d_rdata;
      S_B_IF_ACK:   return 32'(b_if_ack);
      default:      return '1;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares probes, acks and memory-port activity against the scoreboard
  always @(negedge clk) begin
    probe_t keep[$];
    ack_t   e;
    acc_t   a;
    if (!done) begin
      keep = {};
      foreach (probe_q[i]) begin
        if (probe_q[i].cyc == cyc) check(probe_q[i].name, sig(probe_q[i].sel), probe_q[i].exp);
        else keep.push_back(probe_q[i]);
      end
      probe_q = keep;

      if (if_ack || d_ack) begin
        check("ack_exclusive", 32'(if_ack & d_ack), 32'd0);
        check("ack_not_back_to_back", 32'(prev_ack), 32'd0);
        if (ack_q.size() == 0) check("spurious_ack", 32'(if_ack | d_ack), 32'd0);
        else begin
          e = ack_q.pop_front();
          check("ack_port_is_d", 32'(d_ack), 32'(e.is_d));
          check("ack_cycle", 32'(cyc), 32'(e.cyc));
          check("ack_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
        end
      end
      prev_ack = if_ack | d_ack;

      if (busy) busy_cnt++;
      if (mem_en) begin
        en_cnt++;
        if (acc_q.size() == 0) check("spurious_mem_en", 32'(mem_en), 32'd0);
        else begin
          check("mem_addr", mem_addr, acc_q[0].addr);
          check("mem_we", 32'(mem_we), 32'(acc_q[0].we));
          if (acc_q[0].we) check("mem_wdata", mem_wdata, acc_q[0].wdata);
        end
      end
      if (!busy && busy_cnt > 0) begin
        if (acc_q.size() == 0) check("spurious_busy", 32'(busy_cnt), 32'd0);
        else begin
          a = acc_q.pop_front();
          check("mem_en_len", 32'(en_cnt), 32'(a.en_len));
          check("busy_len", 32'(busy_cnt), 32'(a.busy_len));
        end
        en_cnt   = 0;
        busy_cnt = 0;
      end
    end else begin
      check("acks_outstanding", 32'(ack_q.size()), 32'd0);
      check("accesses_outstanding", 32'(acc_q.size()), 32'd0);
      check("probes_outstanding", 32'(probe_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic probe(int dc, int sel, logic [31:0] exp, string name);
    probe_q.push_back('{cyc + dc, sel, exp, name});
  endtask

  task automatic wait_ack(bit is_d);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (is_d ? d_ack : if_ack) break;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0;
    b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset values while reset is held
    probe(1, S_MEM_EN, 0, "rst_mem_en");     probe(1, S_MEM_WE, 0, "rst_mem_we");
    probe(1, S_IF_ACK, 0, "rst_if_ack");     probe(1, S_D_ACK, 0, "rst_d_ack");
    probe(1, S_BUSY, 0, "rst_busy");         probe(1, S_MEM_ADDR, 0, "rst_mem_addr");
    probe(1, S_MEM_WDATA, 0, "rst_mem_wdata"); probe(1, S_IF_RDATA, 0, "rst_if_rdata");
    probe(1, S_D_RDATA, 0, "rst_d_rdata");   probe(1, S_B_MEM_EN, 0, "rst_b_mem_en");
    probe(1, S_B_D_ACK, 0, "rst_b_d_ack");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Fetch alone
    if_req = 1'b1; if_addr = 32'h40;
    ack_q.push_back('{1'b0, 32'h2010FFFF, cyc + 3});
    acc_q.push_back('{32'h40, 1'b0, 32'h0, 2, 3});
    probe(1, S_MEM_EN, 1, "f_mem_en_c1"); probe(2, S_MEM_EN, 1, "f_mem_en_c2");
    probe(3, S_MEM_EN, 0, "f_mem_en_c3"); probe(3, S_D_ACK, 0, "f_d_ack_c3");
    probe(4, S_IF_ACK, 0, "f_if_ack_c4");
    wait_ack(1'b0);
    if_req = 1'b0;
    repeat (2) @(negedge clk);

    // Store; the requester's inputs change after the grant and must be ignored
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    ack_q.push_back('{1'b1, 32'h2010FEBF, cyc + 3});
    acc_q.push_back('{32'h100, 1'b1, 32'hDEADBEEF, 2, 3});
    probe(1, S_BUSY, 1, "s_busy_c1"); probe(2, S_BUSY, 1, "s_busy_c2");
    probe(3, S_BUSY, 1, "s_busy_c3"); probe(3, S_IF_ACK, 0, "s_if_ack_c3");
    probe(3, S_MEM_WE, 0, "s_mem_we_c3");
    @(negedge clk);
    d_addr = 32'hBAD0; d_wdata = 32'h0;
    wait_ack(1'b1);
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(negedge clk);

    // Contention after reset: D, IF, then again D, IF
    do_reset();
    for (int r = 0; r < 2; r++) begin
      if_addr = (r == 0) ? 32'h80 : 32'hC0;
      d_addr  = (r == 0) ? 32'h200 : 32'h300;
      d_we = 1'b0; if_req = 1'b1; d_req = 1'b1;
      ack_q.push_back('{1'b1, (r == 0) ? 32'h2010FDBF : 32'h2010FCBF, cyc + 3});
      ack_q.push_back('{1'b0, (r == 0) ? 32'h2010FF3F : 32'h2010FF7F, cyc + 7});
      acc_q.push_back('{(r == 0) ? 32'h200 : 32'h300, 1'b0, 32'h0, 2, 3});
      acc_q.push_back('{(r == 0) ? 32'h80 : 32'hC0, 1'b0, 32'h0, 2, 3});
      probe(4, S_BUSY, 0, "c_idle_gap"); probe(5, S_MEM_EN, 1, "c_if_access");
      fork
        begin wait_ack(1'b1); d_req = 1'b0; end
        begin wait_ack(1'b0); if_req = 1'b0; end
      join
      @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Reset during ACCESS: no ack, port idle on the next cycle
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h180;
    acc_q.push_back('{32'h180, 1'b0, 32'h0, 2, 2});
    probe(3, S_MEM_EN, 0, "r_mem_en_c3"); probe(3, S_BUSY, 0, "r_busy_c3");
    probe(3, S_D_ACK, 0, "r_d_ack_c3");   probe(4, S_D_ACK, 0, "r_d_ack_c4");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; d_req = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h44;
    ack_q.push_back('{1'b0, 32'h2010FFFB, cyc + 3});
    acc_q.push_back('{32'h44, 1'b0, 32'h0, 2, 3});
    wait_ack(1'b0);
    if_req = 1'b0;
    repeat (2) @(negedge clk);

    // Held fetch request: second access after a one-cycle IDLE gap
    if_req = 1'b1; if_addr = 32'h48;
    ack_q.push_back('{1'b0, 32'h2010FFF7, cyc + 3});
    ack_q.push_back('{1'b0, 32'h2010FFF7, cyc + 7});
    acc_q.push_back('{32'h48, 1'b0, 32'h0, 2, 3});
    acc_q.push_back('{32'h48, 1'b0, 32'h0, 2, 3});
    probe(4, S_IF_ACK, 0, "h_if_ack_c4"); probe(4, S_MEM_EN, 0, "h_mem_en_c4");
    probe(5, S_MEM_EN, 1, "h_mem_en_c5");
    wait_ack(1'b0);
    wait_ack(1'b0);
    if_req = 1'b0;
    repeat (2) @(negedge clk);

    // Single wait state instance: load
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h10;
    probe(1, S_B_MEM_EN, 1, "w1_mem_en_c1"); probe(1, S_B_MEM_ADDR, 32'h10, "w1_mem_addr_c1");
    probe(1, S_B_D_ACK, 0, "w1_d_ack_c1");   probe(2, S_B_MEM_EN, 0, "w1_mem_en_c2");
    probe(2, S_B_D_ACK, 1, "w1_d_ack_c2");   probe(2, S_B_D_RDATA, 32'h2010FFAF, "w1_d_rdata_c2");
    probe(2, S_B_IF_ACK, 0, "w1_if_ack_c2"); probe(3, S_B_D_ACK, 0, "w1_d_ack_c3");
    repeat (2) @(negedge clk);
    b_d_req = 1'b0;
    repeat (4) @(negedge clk);
    done = 1'b1;
  end

endmodule
